// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for the mono sample path.
// Divides clk down to BCLK, runs a 32-slot frame (16 bits left, 16 bits right)
// and requests one 8-bit sample per frame with sample_tick. The sample is
// widened to 16-bit PCM and sent on both channels, MSB first, with the
// standard one-BCLK delay after word-select changes.
// Optional build macro: I2S_MUTE_EN adds a 'mute' input that zeroes whole
// frames at the slot-0 load.
module i2s_tx #(
  parameter int unsigned BCLK_DIV  = 9,
  parameter bit          SIGNED_IN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mono_sample,
`ifdef I2S_MUTE_EN
  input  logic       mute,
`endif
  output logic       sample_tick,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata
);

  localparam int unsigned      DIV_W    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic [4:0]       slot_next;
  logic [31:0]      shreg;
  logic [15:0]      word;
  logic [31:0]      load_word;
  logic             div_wrap;

  // Sample-to-PCM conversion and the frame word presented at the slot-0 load
  always_comb begin
    word = '0;
    if (SIGNED_IN) begin
      word = {mono_sample, 8'h00};
    end else begin
      word = {~mono_sample[7], mono_sample[6:0], 8'h00};
    end
`ifdef I2S_MUTE_EN
    load_word = mute ? '0 : {word, word};
`else
    load_word = {word, word};
`endif
    slot_next = slot + 5'd1;
    div_wrap  = (div_cnt == DIV_LAST);
  end

  // Divider, slot counter, shifter and request pulse; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      slot        <= '0;
      shreg       <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (i2s_bclk) begin
          // Falling BCLK: advance slot; sdata takes the old MSB even on the
          // load edge, which delivers the previous right LSB in slot 0.
          slot      <= slot_next;
          i2s_lrclk <= slot_next[4];
          i2s_sdata <= shreg[31];
          if (slot_next == 5'd0) begin
            shreg <= load_word;
          end else begin
            shreg <= {shreg[30:0], 1'b0};
          end
          if (slot_next == 5'd31) begin
            sample_tick <= 1'b1;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with BCLK_DIV=2 (frame = 128 clk).
// Two instances run in lockstep: unsigned input (u_dut0) and signed (u_dut1).
// Define I2S_MUTE_EN for both files to exercise the mute input.
`timescale 1ns/1ps
module tb_i2s_tx;

  localparam int unsigned DIV   = 2;
  localparam int unsigned FRAME = 64 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ms0 = 8'h00;
  logic [7:0] ms1 = 8'h00;
  logic       tick0, bclk0, lr0, sd0;
  logic       tick1, bclk1, lr1, sd1;
`ifdef I2S_MUTE_EN
  logic       mute = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  i2s_tx #(.BCLK_DIV(DIV), .SIGNED_IN(1'b0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .mono_sample (ms0),
`ifdef I2S_MUTE_EN
    .mute        (mute),
`endif
    .sample_tick (tick0),
    .i2s_bclk    (bclk0),
    .i2s_lrclk   (lr0),
    .i2s_sdata   (sd0)
  );

  i2s_tx #(.BCLK_DIV(DIV), .SIGNED_IN(1'b1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .mono_sample (ms1),
`ifdef I2S_MUTE_EN
    .mute        (1'b0),
`endif
    .sample_tick (tick1),
    .i2s_bclk    (bclk1),
    .i2s_lrclk   (lr1),
    .i2s_sdata   (sd1)
  );

  always #5 clk = ~clk;

  // Serial decoder: shifts sdata on each BCLK rise, emits one 32-bit word per
  // frame at the slot-0 rise, and records tick times and timing anomalies.
  int          cyc = 0;
  int          rc0 = 0, rc1 = 0;
  logic [31:0] sh0 = '0, sh1 = '0;
  logic        pb0 = 1'b0, pb1 = 1'b0, psd0 = 1'b0, ptick0 = 1'b0;
  int          lr_bad = 0, sd_bad = 0, tick_wide = 0;
  logic [31:0] words0[$];
  logic [31:0] words1[$];
  int          tick_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      rc0 = 0; rc1 = 0; sh0 = '0; sh1 = '0;
      pb0 = 1'b0; pb1 = 1'b0; psd0 = 1'b0; ptick0 = 1'b0;
      words0.delete();
      words1.delete();
    end else begin
      if (sd0 !== psd0 && !(pb0 && !bclk0)) sd_bad++;
      if (bclk0 && !pb0) begin
        sh0 = {sh0[30:0], sd0};
        if (lr0 !== ((rc0 % 32) >= 16)) lr_bad++;
        if (rc0 != 0 && (rc0 % 32) == 0) words0.push_back(sh0);
        rc0++;
      end
      if (bclk1 && !pb1) begin
        sh1 = {sh1[30:0], sd1};
        if (rc1 != 0 && (rc1 % 32) == 0) words1.push_back(sh1);
        rc1++;
      end
      if (tick0) begin
        tick_q.push_back(cyc);
        if (ptick0) tick_wide++;
      end
      pb0 = bclk0; pb1 = bclk1; psd0 = sd0; ptick0 = tick0;
    end
  end

  task automatic wait_words(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (words0.size() >= target && words1.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tick0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_lr_rise(output bit ok);
    logic plr;
    ok  = 1'b0;
    plr = lr0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!plr && lr0) begin
        ok = 1'b1;
        break;
      end
      plr = lr0;
    end
  endtask

  task automatic test_reset();
    int   zero_bad;
    logic exp;
    rst = 1'b1; ms0 = 8'h00; ms1 = 8'h00;
    repeat (5) @(negedge clk);
    checks++;
    if ({tick0, bclk0, lr0, sd0, tick1, bclk1, lr1, sd1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {tick0, bclk0, lr0, sd0, tick1, bclk1, lr1, sd1});
    end
    rst = 1'b0;
    zero_bad = 0;
    for (int k = 1; k <= 132; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        exp = ((k / 2) % 2) == 1;
        checks++;
        if (bclk0 !== exp) begin
          errors++;
          $display("FAIL bclk_edge%0d: got %b required %b", k, bclk0, exp);
        end
      end
      if (k == 63 || k == 64 || k == 127 || k == 128) begin
        exp = (k == 64 || k == 127);
        checks++;
        if (lr0 !== exp) begin
          errors++;
          $display("FAIL lrclk_edge%0d: got %b required %b", k, lr0, exp);
        end
      end
      if (k >= 123 && k <= 125) begin
        exp = (k == 124);
        checks++;
        if (tick0 !== exp) begin
          errors++;
          $display("FAIL first_tick_edge%0d: got %b required %b", k, tick0, exp);
        end
      end
      if (k <= 131 && sd0 !== 1'b0) zero_bad++;
      if (k == 132) begin
        checks++;
        if (sd0 !== 1'b1) begin
          errors++;
          $display("FAIL first_load_msb: got %b required 1", sd0);
        end
      end
    end
    checks++;
    if (zero_bad !== 0) begin
      errors++;
      $display("FAIL first_frame_zero: got %0d nonzero bits required 0", zero_bad);
    end
  endtask

  task automatic test_data_map();
    logic [7:0]  in0 [3] = '{8'hFF, 8'h80, 8'h00};
    logic [31:0] ex0 [3] = '{32'h7F007F00, 32'h00000000, 32'h80008000};
    logic [7:0]  in1 [3] = '{8'h80, 8'h7F, 8'h01};
    logic [31:0] ex1 [3] = '{32'h80008000, 32'h7F007F00, 32'h01000100};
    int n;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      ms0 = in0[i];
      ms1 = in1[i];
      n = words0.size();
      wait_words(n + 3, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL data_map_timeout%0d: got %0d words required %0d", i, words0.size(), n + 3);
      end else begin
        checks++;
        if (words0[n + 2] !== ex0[i]) begin
          errors++;
          $display("FAIL map_unsigned_%h: got %h required %h", in0[i], words0[n + 2], ex0[i]);
        end
        checks++;
        if (words1[n + 2] !== ex1[i]) begin
          errors++;
          $display("FAIL map_signed_%h: got %h required %h", in1[i], words1[n + 2], ex1[i]);
        end
      end
    end
  endtask

  task automatic test_tick_handshake();
    int tw0, bad_gap, n;
    bit ok1, ok2, ok3;
    tick_q.delete();
    tw0 = tick_wide;
    repeat (10 * FRAME) @(negedge clk);
    checks++;
    if (tick_q.size() !== 10) begin
      errors++;
      $display("FAIL tick_count: got %0d required 10", tick_q.size());
    end
    checks++;
    if (tick_wide !== tw0) begin
      errors++;
      $display("FAIL tick_width: got %0d wide pulses required 0", tick_wide - tw0);
    end
    bad_gap = 0;
    for (int i = 1; i < tick_q.size(); i++)
      if (tick_q[i] - tick_q[i - 1] != FRAME) bad_gap++;
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL tick_spacing: got %0d bad gaps required 0", bad_gap);
    end
    ms0 = 8'h10;
    wait_tick(ok1);
    wait_tick(ok2);
    n = words0.size();
    @(negedge clk);
    ms0 = 8'hC0;
    wait_words(n + 2, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      errors++;
      $display("FAIL handshake_timeout: got %b%b%b required 111", ok1, ok2, ok3);
    end else begin
      checks++;
      if (words0[n] !== 32'h90009000) begin
        errors++;
        $display("FAIL handshake_old: got %h required 90009000", words0[n]);
      end
      checks++;
      if (words0[n + 1] !== 32'h40004000) begin
        errors++;
        $display("FAIL handshake_new: got %h required 40004000", words0[n + 1]);
      end
    end
  endtask

  task automatic test_alignment();
    int   n;
    bit   ok, found;
    logic plr, pbk;
    ms0 = 8'h7F;
    n = words0.size();
    wait_words(n + 3, ok);
    checks++;
    if (!ok || words0[words0.size() - 1] !== 32'hFF00FF00) begin
      errors++;
      $display("FAIL align_word: got %h required ff00ff00", words0[words0.size() - 1]);
    end
    found = 1'b0;
    plr = lr0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (plr && !lr0) begin found = 1'b1; break; end
      plr = lr0;
    end
    checks++;
    if (!found || sd0 !== 1'b0 || bclk0 !== 1'b0) begin
      errors++;
      $display("FAIL slot0_prev_lsb: got found=%b sdata=%b bclk=%b required 1 0 0", found, sd0, bclk0);
    end
    found = 1'b0;
    pbk = bclk0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pbk && !bclk0) begin found = 1'b1; break; end
      pbk = bclk0;
    end
    checks++;
    if (!found || sd0 !== 1'b1) begin
      errors++;
      $display("FAIL slot1_left_msb: got found=%b sdata=%b required 1 1", found, sd0);
    end
    checks++;
    if (lr_bad !== 0) begin
      errors++;
      $display("FAIL lrclk_slot_align: got %0d bad slots required 0", lr_bad);
    end
    checks++;
    if (sd_bad !== 0) begin
      errors++;
      $display("FAIL sdata_fall_only: got %0d bad changes required 0", sd_bad);
    end
  endtask

  task automatic test_midframe_reset();
    bit   ok;
    int   falls;
    logic pbk;
    logic exp;
    ms0 = 8'hFF;
    wait_lr_rise(ok);
    falls = 0;
    pbk = bclk0;
    for (int i = 0; i < 40 && falls < 4; i++) begin
      @(negedge clk);
      if (pbk && !bclk0) falls++;
      pbk = bclk0;
    end
    checks++;
    if (!ok || falls != 4 || lr0 !== 1'b1) begin
      errors++;
      $display("FAIL reach_slot20: got ok=%b falls=%0d lrclk=%b required 1 4 1", ok, falls, lr0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bclk0, lr0, sd0, tick0} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 0000", {bclk0, lr0, sd0, tick0});
    end
    rst = 1'b0;
    for (int k = 1; k <= 125; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2 || k == 4) begin
        exp = (k == 2);
        checks++;
        if (bclk0 !== exp) begin
          errors++;
          $display("FAIL rst_bclk_edge%0d: got %b required %b", k, bclk0, exp);
        end
      end
      if (k == 63 || k == 64) begin
        exp = (k == 64);
        checks++;
        if (lr0 !== exp) begin
          errors++;
          $display("FAIL rst_lrclk_edge%0d: got %b required %b", k, lr0, exp);
        end
      end
      if (k == 123 || k == 124) begin
        exp = (k == 124);
        checks++;
        if (tick0 !== exp) begin
          errors++;
          $display("FAIL rst_tick_edge%0d: got %b required %b", k, tick0, exp);
        end
      end
    end
    wait_words(2, ok);
    checks++;
    if (!ok || words0[0] !== 32'h0 || words0[1] !== 32'h7F007F00) begin
      errors++;
      $display("FAIL rst_restart_words: got ok=%b %h %h required 1 00000000 7f007f00",
               ok, words0[0], words0[1]);
    end
  endtask

`ifdef I2S_MUTE_EN
  task automatic test_mute();
    bit ok, okw;
    int n, m;
    ms0 = 8'hFF;
    mute = 1'b0;
    wait_lr_rise(ok);
    mute = 1'b1;
    n = words0.size();
    tick_q.delete();
    wait_words(n + 3, okw);
    checks++;
    if (!(ok && okw) || words0[n] !== 32'h7F007F00) begin
      errors++;
      $display("FAIL mute_current_frame: got %h required 7f007f00", words0[n]);
    end
    checks++;
    if (!okw || words0[n + 1] !== 32'h0 || words0[n + 2] !== 32'h0) begin
      errors++;
      $display("FAIL mute_frames_zero: got %h %h required 0 0", words0[n + 1], words0[n + 2]);
    end
    checks++;
    if (tick_q.size() !== 3) begin
      errors++;
      $display("FAIL mute_ticks: got %0d required 3", tick_q.size());
    end
    wait_lr_rise(ok);
    mute = 1'b0;
    m = words0.size();
    wait_words(m + 2, okw);
    checks++;
    if (!(ok && okw) || words0[m] !== 32'h0 || words0[m + 1] !== 32'h7F007F00) begin
      errors++;
      $display("FAIL unmute_resume: got %h %h required 00000000 7f007f00", words0[m], words0[m + 1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_data_map();
    test_tick_handshake();
    test_alignment();
    test_midframe_reset();
`ifdef I2S_MUTE_EN
    test_mute();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
